clip_sequencer: RTL

Controls the two 16-bit × 131072-entry clip memories in the audio recorder, one operation at a time. It records incoming PCM samples into the selected clip on each sample tick and tracks each clip's stored length. It plays a clip back by issuing BRAM reads and presenting the returned samples on `sample_out`. It sits between the sample-rate clock domain logic (`sample_tick`, ADC/DAC sample registers) and the two single-port BRAMs, and drives the status inputs of the seven-segment display.

---
 rtl/clip_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/clip_sequencer.sv
// Record/playback sequencer for two single-port clip BRAMs sharing one address/data bus.
// One operation at a time: record on sample ticks, or play back with a one-cycle read latency.
module clip_sequencer #(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 131072
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sample_tick,
   input  logic              record,
   input  logic              play,
   input  logic              clip_rec_sel,
   input  logic              clip_play_sel,
   input  logic [DATA_W-1:0] sample_in,
   output logic [DATA_W-1:0] sample_out,
   output logic [1:0]        mem_ena,
   output logic [1:0]        mem_wea,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout0,
   input  logic [DATA_W-1:0] mem_dout1,
   output logic              rec_busy,
   output logic              play_busy,
   output logic              active_clip,
   output logic [1:0]        clip_valid
);

   localparam int unsigned LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, REC, PLAY_RD, PLAY_LAT} state_t;

   state_t            state;
   logic              rec_q, rec_prev, play_q, play_prev;
   logic              rec_rise, play_rise;
   logic [LEN_W-1:0]  ptr, ptr_inc, len0, len1, cur_len, sel_len;
   logic [DATA_W-1:0] rd_data;
   logic              wr_cycle, rd_cycle;

   assign rec_rise  = rec_q & ~rec_prev;
   assign play_rise = play_q & ~play_prev;
   assign ptr_inc   = ptr + LEN_W'(1);
   assign cur_len   = active_clip ? len1 : len0;
   assign sel_len   = clip_play_sel ? len1 : len0;
   assign rd_data   = active_clip ? mem_dout1 : mem_dout0;

   assign rec_busy   = (state == REC);
   assign play_busy  = (state == PLAY_RD) || (state == PLAY_LAT);
   assign clip_valid = {|len1, |len0};

   // A record rise pre-empts a read issued in the same cycle.
   assign wr_cycle = (state == REC) && sample_tick;
   assign rd_cycle = (state == PLAY_RD) && sample_tick && !rec_rise;
   assign mem_addr = ptr[ADDR_W-1:0];

   always_comb begin
      mem_ena = '0;
      mem_wea = '0;
      mem_din = '0;
      if (wr_cycle) begin
         mem_ena[active_clip] = 1'b1;
         mem_wea[active_clip] = 1'b1;
         mem_din              = sample_in;
      end else if (rd_cycle) begin
         mem_ena[active_clip] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         rec_q       <= 1'b0;
         rec_prev    <= 1'b0;
         play_q      <= 1'b0;
         play_prev   <= 1'b0;
         ptr         <= '0;
         len0        <= '0;
         len1        <= '0;
         sample_out  <= '0;
         active_clip <= 1'b0;
      end else begin
         rec_q     <= record;
         rec_prev  <= rec_q;
         play_q    <= play;
         play_prev <= play_q;

         if (state == IDLE && sample_tick)
            sample_out <= '0;

         // Record start wins over play start and aborts any playback.
         if (rec_rise && state != REC) begin
            state       <= REC;
            active_clip <= clip_rec_sel;
            ptr         <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (play_rise && sel_len != '0) begin
                     state       <= PLAY_RD;
                     active_clip <= clip_play_sel;
                     ptr         <= '0;
                  end
               end
               REC: begin
                  if (sample_tick) begin
                     ptr <= ptr_inc;
                     if (ptr_inc == LEN_FULL || !rec_q) begin
                        if (active_clip) len1 <= ptr_inc;
                        else             len0 <= ptr_inc;
                        state <= IDLE;
                     end
                  end else if (!rec_q) begin
                     if (active_clip) len1 <= ptr;
                     else             len0 <= ptr;
                     state <= IDLE;
                  end
               end
               PLAY_RD: begin
                  if (sample_tick)
                     state <= PLAY_LAT;
               end
               PLAY_LAT: begin
                  sample_out <= rd_data;
                  ptr        <= ptr_inc;
                  state      <= (ptr_inc == cur_len) ? IDLE : PLAY_RD;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
